// File: rtl/touch_draw_ctrl.sv
// touch_draw_ctrl: turns touch samples into video RAM pixel writes and sweeps a full-screen clear.
// Define TOUCH_BRUSH_3X3_EN to paint a 3x3 brush around each touch instead of a single pixel.
module touch_draw_ctrl #(
    parameter int         X_RES    = 480,
    parameter int         Y_RES    = 272,
    parameter logic [8:0] BG_COLOR = 9'h000
) (
    input  logic       cclk,
    input  logic       rstb,
    input  logic       touch_valid,
    input  logic [8:0] touch_x,
    input  logic [8:0] touch_y,
    input  logic [8:0] color_sel,
    input  logic       clear_btn,
    output logic       wr_ena,
    output logic [8:0] wr_x,
    output logic [8:0] wr_y,
    output logic [8:0] wr_data,
    output logic       clear_busy,
    output logic       clear_done
);
    typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

    localparam logic [10:0] XR = 11'(X_RES);
    localparam logic [10:0] YR = 11'(Y_RES);
    localparam logic [8:0]  XL = 9'(X_RES - 1);
    localparam logic [8:0]  YL = 9'(Y_RES - 1);

    state_t     r_state, w_state;
    logic       r_clr_q, r_pend, w_pend;
    logic       r_wr_ena, r_busy, r_done, w_ena, w_busy, w_done;
    logic [8:0] r_wr_x, r_wr_y, r_wr_data, w_wx, w_wy, w_wd;
    logic       w_rise, w_touch_ok, w_last;

    assign w_rise     = clear_btn & ~r_clr_q;
    assign w_touch_ok = touch_valid && ({2'b0, touch_x} < XR) && ({2'b0, touch_y} < YR);

`ifdef TOUCH_BRUSH_3X3_EN
    logic [8:0]  r_x, r_y, r_col, w_x, w_y, w_col, w_base_x, w_base_y;
    logic [1:0]  r_bx, r_by, w_bx, w_by, w_nbx, w_nby;
    logic [10:0] w_px, w_py;
    logic        w_in;

    assign w_base_x = (r_state == DRAW) ? r_x : touch_x;
    assign w_base_y = (r_state == DRAW) ? r_y : touch_y;
    assign w_nbx    = (r_state != DRAW || r_bx == 2'd2) ? 2'd0 : r_bx + 2'd1;
    assign w_nby    = (r_state != DRAW) ? 2'd0 : (r_bx == 2'd2) ? r_by + 2'd1 : r_by;
    // 11-bit offsets: a -1 at the screen edge lands far above the resolution instead of wrapping onto 511
    assign w_px     = {2'b0, w_base_x} + {9'b0, w_nbx} - 11'd1;
    assign w_py     = {2'b0, w_base_y} + {9'b0, w_nby} - 11'd1;
    assign w_in     = (w_px < XR) && (w_py < YR);
    assign w_last   = (r_bx == 2'd2) && (r_by == 2'd2);
`else
    assign w_last   = 1'b1;
`endif

    always_comb begin
        w_state = r_state;
        w_pend  = r_pend;
        w_ena   = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_wx    = r_wr_x;
        w_wy    = r_wr_y;
        w_wd    = r_wr_data;
`ifdef TOUCH_BRUSH_3X3_EN
        w_x     = r_x;
        w_y     = r_y;
        w_col   = r_col;
        w_bx    = r_bx;
        w_by    = r_by;
`endif
        case (r_state)
            IDLE: if (!w_rise && w_touch_ok) begin
                w_state = DRAW;
`ifdef TOUCH_BRUSH_3X3_EN
                w_x     = touch_x;
                w_y     = touch_y;
                w_col   = color_sel;
`else
                w_ena   = 1'b1;
                w_wx    = touch_x;
                w_wy    = touch_y;
                w_wd    = color_sel;
`endif
            end
            DRAW: begin
                w_pend = r_pend | w_rise;
                if (w_last) w_state = IDLE;
            end
            CLEAR: if (r_wr_x == XL && r_wr_y == YL) begin
                w_state = DONE;
                w_done  = 1'b1;
            end else begin
                w_ena   = 1'b1;
                w_busy  = 1'b1;
                w_wx    = (r_wr_x == XL) ? 9'd0 : r_wr_x + 9'd1;
                w_wy    = (r_wr_x == XL) ? r_wr_y + 9'd1 : r_wr_y;
            end
            DONE: w_state = IDLE;
        endcase
`ifdef TOUCH_BRUSH_3X3_EN
        if (w_state == DRAW) begin
            w_bx  = w_nbx;
            w_by  = w_nby;
            w_ena = w_in;
            if (w_in) begin
                w_wx = w_px[8:0];
                w_wy = w_py[8:0];
                w_wd = w_col;
            end
        end
`endif
        // The first sweep pixel is written on the same edge that enters CLEAR
        if ((r_state == IDLE && w_rise) || (r_state == DRAW && w_last && w_pend)) begin
            w_state = CLEAR;
            w_pend  = 1'b0;
            w_ena   = 1'b1;
            w_busy  = 1'b1;
            w_wx    = 9'd0;
            w_wy    = 9'd0;
            w_wd    = BG_COLOR;
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= IDLE;
            r_clr_q   <= 1'b0;
            r_pend    <= 1'b0;
            r_wr_ena  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_x    <= 9'd0;
            r_wr_y    <= 9'd0;
            r_wr_data <= 9'd0;
`ifdef TOUCH_BRUSH_3X3_EN
            r_x       <= 9'd0;
            r_y       <= 9'd0;
            r_col     <= 9'd0;
            r_bx      <= 2'd0;
            r_by      <= 2'd0;
`endif
        end else begin
            r_state   <= w_state;
            r_clr_q   <= clear_btn;
            r_pend    <= w_pend;
            r_wr_ena  <= w_ena;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_wr_x    <= w_wx;
            r_wr_y    <= w_wy;
            r_wr_data <= w_wd;
`ifdef TOUCH_BRUSH_3X3_EN
            r_x       <= w_x;
            r_y       <= w_y;
            r_col     <= w_col;
            r_bx      <= w_bx;
            r_by      <= w_by;
`endif
        end
    end

    assign wr_ena     = r_wr_ena;
    assign wr_x       = r_wr_x;
    assign wr_y       = r_wr_y;
    assign wr_data    = r_wr_data;
    assign clear_busy = r_busy;
    assign clear_done = r_done;
endmodule

// File: tb/tb_touch_draw_ctrl.sv
// tb_touch_draw_ctrl: randomized self-checking bench for touch_draw_ctrl on a reduced 120x60 screen.
module tb_touch_draw_ctrl;
    localparam int XR = 120;
    localparam int YR = 60;
    localparam int N  = XR * YR;
    localparam logic [8:0] BG = 9'h0A5;
`ifdef TOUCH_BRUSH_3X3_EN
    localparam int NPIX = 9;
`else
    localparam int NPIX = 1;
`endif
    localparam int P = NPIX + 1;

    logic       cclk = 1'b0;
    logic       rstb = 1'b0;
    logic       touch_valid = 1'b0;
    logic [8:0] touch_x = 9'd0;
    logic [8:0] touch_y = 9'd0;
    logic [8:0] color_sel = 9'd0;
    logic       clear_btn = 1'b0;
    logic       wr_ena, clear_busy, clear_done;
    logic [8:0] wr_x, wr_y, wr_data;

    int total = 0;
    int bad = 0;
    logic [8:0] m_x = 9'd0, m_y = 9'd0, m_d = 9'd0;

    touch_draw_ctrl #(.X_RES(XR), .Y_RES(YR), .BG_COLOR(BG)) dut (
        .cclk(cclk), .rstb(rstb), .touch_valid(touch_valid), .touch_x(touch_x),
        .touch_y(touch_y), .color_sel(color_sel), .clear_btn(clear_btn),
        .wr_ena(wr_ena), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 cclk = ~cclk;

    function automatic logic [29:0] obs();
        return {wr_ena, wr_x, wr_y, wr_data, clear_busy, clear_done};
    endfunction

    // Pixel k of the brush footprint around (x,y): {on_screen, px, py}
    function automatic logic [18:0] brush_px(int x, int y, int k);
        int px, py;
`ifdef TOUCH_BRUSH_3X3_EN
        px = x + k % 3 - 1;
        py = y + k / 3 - 1;
`else
        px = x;
        py = y;
`endif
        return {(px >= 0 && px < XR && py >= 0 && py < YR), 9'(px), 9'(py)};
    endfunction

    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(negedge cclk);
        total += 6;
        if (wr_ena !== 1'b0)     begin bad++; $display("FAIL reset wr_ena got=%b want=0", wr_ena); end
        if (wr_x !== 9'd0)       begin bad++; $display("FAIL reset wr_x got=%0d want=0", wr_x); end
        if (wr_y !== 9'd0)       begin bad++; $display("FAIL reset wr_y got=%0d want=0", wr_y); end
        if (wr_data !== 9'd0)    begin bad++; $display("FAIL reset wr_data got=%h want=0", wr_data); end
        if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset clear_busy got=%b want=0", clear_busy); end
        if (clear_done !== 1'b0) begin bad++; $display("FAIL reset clear_done got=%b want=0", clear_done); end
        rstb = 1'b1;
    endtask

    task automatic test_touch();
        int tx[7] = '{100, 0, XR - 1, XR, 10, 480, 511};
        int ty[7] = '{50, 0, YR - 1, 10, YR, 10, 511};
        for (int t = 0; t < 40; t++) begin
            int x, y;
            logic [8:0] c;
            logic [18:0] pix;
            logic ok;
            logic [29:0] exp;
            if (t < 7) begin
                x = tx[t]; y = ty[t]; c = (t == 0) ? 9'h1C0 : 9'($urandom);
            end else begin
                x = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : XR - 1) : $urandom_range(0, XR + 8);
                y = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : YR - 1) : $urandom_range(0, YR + 8);
                c = 9'($urandom);
            end
            @(negedge cclk);
            touch_valid = 1'b1; touch_x = 9'(x); touch_y = 9'(y); color_sel = c;
            for (int s = 0; s < P; s++) begin
                @(negedge cclk);
                touch_valid = 1'b0;
                pix = brush_px(x, y, s);
                ok = (x < XR) && (y < YR) && (s < NPIX) && pix[18];
                if (ok) begin m_x = pix[17:9]; m_y = pix[8:0]; m_d = c; end
                exp = {ok, m_x, m_y, m_d, 2'b00};
                total++;
                if (obs() !== exp) begin
                    bad++;
                    $display("FAIL touch(%0d,%0d) s=%0d got=%h want=%h", x, y, s, obs(), exp);
                end
            end
        end
    endtask

    task automatic test_held_touch();
        for (int t = 0; t < 4; t++) begin
            int x = $urandom_range(0, XR - 1);
            int y = $urandom_range(0, YR - 1);
            logic [8:0] cur_c = 9'($urandom);
            logic [8:0] cap_c = 9'd0;
            logic [18:0] pix;
            logic ok;
            logic [29:0] exp;
            @(negedge cclk);
            touch_valid = 1'b1; touch_x = 9'(x); touch_y = 9'(y); color_sel = cur_c;
            for (int s = 0; s < 3 * P; s++) begin
                @(negedge cclk);
                if (s % P == 0) cap_c = cur_c;
                pix = brush_px(x, y, s % P);
                ok = (s % P < NPIX) && pix[18];
                if (ok) begin m_x = pix[17:9]; m_y = pix[8:0]; m_d = cap_c; end
                exp = {ok, m_x, m_y, m_d, 2'b00};
                total++;
                if (obs() !== exp) begin
                    bad++;
                    $display("FAIL held(%0d,%0d) s=%0d got=%h want=%h", x, y, s, obs(), exp);
                end
                cur_c = 9'($urandom);
                color_sel = cur_c;
                if (s == 3 * P - 1) touch_valid = 1'b0;
            end
        end
    endtask

    task automatic test_clear();
        logic [29:0] exp;
        @(negedge cclk);
        clear_btn = 1'b1;
        for (int s = 0; s < N + 2; s++) begin
            @(negedge cclk);
            if (s < N) begin
                m_x = 9'(s % XR); m_y = 9'(s / XR); m_d = BG;
                exp = {1'b1, m_x, m_y, m_d, 2'b10};
            end else begin
                exp = {1'b0, m_x, m_y, m_d, 1'b0, (s == N)};
            end
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL clear s=%0d got=%h want=%h", s, obs(), exp);
            end
            if (s < N - 3) begin
                clear_btn = 1'($urandom);
                touch_valid = 1'($urandom);
                touch_x = 9'($urandom_range(0, XR - 1));
                touch_y = 9'($urandom_range(0, YR - 1));
            end else begin
                clear_btn = 1'b0;
                touch_valid = 1'b0;
            end
        end
    endtask

    task automatic test_pending_clear();
        int ps = (NPIX > 1) ? 2 : 0;
        for (int t = 0; t < 3; t++) begin
            int x = (t == 0) ? 0 : $urandom_range(0, XR - 1);
            int y = (t == 0) ? 0 : $urandom_range(0, YR - 1);
            logic [8:0] c = 9'($urandom);
            logic [18:0] pix;
            logic [29:0] exp;
            @(negedge cclk);
            touch_valid = 1'b1; touch_x = 9'(x); touch_y = 9'(y); color_sel = c;
            for (int s = 0; s < NPIX + 2 * XR + 5; s++) begin
                @(negedge cclk);
                touch_valid = 1'b0;
                if (s < NPIX) begin
                    pix = brush_px(x, y, s);
                    if (pix[18]) begin m_x = pix[17:9]; m_y = pix[8:0]; m_d = c; end
                    exp = {pix[18], m_x, m_y, m_d, 2'b00};
                end else begin
                    m_x = 9'((s - NPIX) % XR); m_y = 9'((s - NPIX) / XR); m_d = BG;
                    exp = {1'b1, m_x, m_y, m_d, 2'b10};
                end
                total++;
                if (obs() !== exp) begin
                    bad++;
                    $display("FAIL pending(%0d,%0d) s=%0d got=%h want=%h", x, y, s, obs(), exp);
                end
                clear_btn = (s == ps);
            end
            rstb = 1'b0;
            @(negedge cclk);
            rstb = 1'b1;
            m_x = 9'd0; m_y = 9'd0; m_d = 9'd0;
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [8:0] c = 9'($urandom);
        logic [18:0] pix;
        logic [29:0] exp;
        @(negedge cclk);
        clear_btn = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            @(negedge cclk);
            clear_btn = 1'b0;
            exp = {1'b1, 9'(s % XR), 9'(s / XR), BG, 2'b10};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL midclear s=%0d got=%h want=%h", s, obs(), exp);
            end
        end
        rstb = 1'b0;
        #1;
        total++;
        if (obs() !== 30'd0) begin bad++; $display("FAIL async_reset got=%h want=0", obs()); end
        m_x = 9'd0; m_y = 9'd0; m_d = 9'd0;
        for (int s = 0; s < 8; s++) begin
            @(negedge cclk);
            if (s == 4) rstb = 1'b1;
            total++;
            if (obs() !== 30'd0) begin bad++; $display("FAIL no_resume s=%0d got=%h want=0", s, obs()); end
        end
        @(negedge cclk);
        touch_valid = 1'b1; touch_x = 9'd5; touch_y = 9'd5; color_sel = c;
        for (int s = 0; s < P; s++) begin
            @(negedge cclk);
            touch_valid = 1'b0;
            pix = brush_px(5, 5, s);
            if (s < NPIX) begin m_x = pix[17:9]; m_y = pix[8:0]; m_d = c; end
            exp = {(s < NPIX), m_x, m_y, m_d, 2'b00};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL after_reset s=%0d got=%h want=%h", s, obs(), exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_touch();
        test_held_touch();
        test_clear();
        test_pending_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
